// File: rtl/alu_16_sequencer.sv
// Command sequencer for a 16-bit cascaded-74181 ALU: registers ALU controls and operands,
// iterates A+A for multi-cycle shifts, and returns result/flags over a valid/ready handshake.
module alu_16_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [3:0]       cmd_select_i,
  input  logic             cmd_mode_i,
  input  logic             cmd_cin_i,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  output logic [3:0]       alu_select_o,
  output logic             alu_mode_o,
  output logic             alu_cin_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_f_i,
  input  logic             alu_cout_i,
  input  logic             alu_equal_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_carry_o,
  output logic             rsp_eq_o,
  output logic             rsp_gt_o,
  output logic             rsp_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_RAW = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [3:0]       cnt_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [3:0]       alu_select_q;
  logic             alu_mode_q;
  logic             alu_cin_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_carry_q;
  logic             rsp_eq_q;
  logic             rsp_gt_q;
  logic             rsp_err_q;
  logic [3:0]       shl_cnt_s;

  assign shl_cnt_s = cmd_b_i[3:0];

  // Sequencer FSM: every output below is a flop updated only here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      op_q         <= 2'b00;
      cnt_q        <= 4'd0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      alu_select_q <= 4'd0;
      alu_mode_q   <= 1'b0;
      alu_cin_q    <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_eq_q     <= 1'b0;
      rsp_gt_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            op_q         <= cmd_op_i;
            cmd_ready_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_eq_q     <= 1'b0;
            rsp_gt_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            case (cmd_op_i)
              OP_RAW: begin
                alu_select_q <= cmd_select_i;
                alu_mode_q   <= cmd_mode_i;
                alu_cin_q    <= cmd_cin_i;
                alu_a_q      <= cmd_a_i;
                alu_b_q      <= cmd_b_i;
                state_q      <= S_EXEC;
              end
              OP_CMP: begin
                // A minus B minus 1 with no carry in: F is all ones exactly when A == B.
                alu_select_q <= 4'b0110;
                alu_mode_q   <= 1'b0;
                alu_cin_q    <= 1'b1;
                alu_a_q      <= cmd_a_i;
                alu_b_q      <= cmd_b_i;
                state_q      <= S_EXEC;
              end
              OP_SHL: begin
                if (shl_cnt_s != 4'd0) begin
                  alu_select_q <= 4'b1100;
                  alu_mode_q   <= 1'b0;
                  alu_cin_q    <= 1'b1;
                  alu_a_q      <= cmd_a_i;
                  alu_b_q      <= '0;
                  cnt_q        <= shl_cnt_s;
                  state_q      <= S_EXEC;
                end else begin
                  rsp_result_q <= cmd_a_i;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= S_DONE;
                end
              end
              default: begin
                rsp_err_q   <= 1'b1;
                rsp_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
            endcase
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_RAW: begin
              rsp_result_q <= alu_f_i;
              rsp_carry_q  <= ~alu_cout_i;
              rsp_eq_q     <= alu_equal_i;
              rsp_gt_q     <= 1'b0;
              rsp_valid_q  <= 1'b1;
              state_q      <= S_DONE;
            end
            OP_CMP: begin
              rsp_result_q <= alu_f_i;
              rsp_carry_q  <= ~alu_cout_i;
              rsp_eq_q     <= alu_equal_i;
              rsp_gt_q     <= ~alu_cout_i;
              rsp_valid_q  <= 1'b1;
              state_q      <= S_DONE;
            end
            OP_SHL: begin
              // Each pass computes A+A; the carry out is the bit shifted off the top.
              alu_a_q     <= alu_f_i;
              rsp_carry_q <= rsp_carry_q | ~alu_cout_i;
              cnt_q       <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin
                rsp_result_q <= alu_f_i;
                rsp_eq_q     <= alu_equal_i;
                rsp_valid_q  <= 1'b1;
                state_q      <= S_DONE;
              end else begin
                state_q <= S_EXEC;
              end
            end
            default: begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          endcase
        end
        S_DONE: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign alu_select_o = alu_select_q;
  assign alu_mode_o   = alu_mode_q;
  assign alu_cin_o    = alu_cin_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_carry_o  = rsp_carry_q;
  assign rsp_eq_o     = rsp_eq_q;
  assign rsp_gt_o     = rsp_gt_q;
  assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_alu_16_sequencer.sv
// Bench for alu_16_sequencer: behavioural 16-bit 74181 model on the ALU side,
// table-driven commands with a response scoreboard, plus backpressure and reset sequences.
module tb_alu_16_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [3:0]   cmd_select;
  logic         cmd_mode, cmd_cin;
  logic [W-1:0] cmd_a, cmd_b;
  logic [3:0]   alu_select;
  logic         alu_mode, alu_cin;
  logic [W-1:0] alu_a, alu_b, alu_f;
  logic         alu_cout, alu_equal;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry, rsp_eq, rsp_gt, rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_16_sequencer #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_select_i(cmd_select), .cmd_mode_i(cmd_mode), .cmd_cin_i(cmd_cin),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .alu_select_o(alu_select), .alu_mode_o(alu_mode), .alu_cin_o(alu_cin),
    .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_f_i(alu_f), .alu_cout_i(alu_cout), .alu_equal_i(alu_equal),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_carry_o(rsp_carry), .rsp_eq_o(rsp_eq), .rsp_gt_o(rsp_gt), .rsp_err_o(rsp_err)
  );

  // 74181 active-high data, inverted carries; returns {cout_n, F}.
  function automatic logic [W:0] alu181(input logic [3:0] s, input logic m, input logic cn,
                                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p, q, f;
    logic [W:0]   sum;
    if (m) begin
      case (s)
        4'b0000: f = ~a;        4'b0001: f = ~(a | b);
        4'b0010: f = ~a & b;    4'b0011: f = '0;
        4'b0100: f = ~(a & b);  4'b0101: f = ~b;
        4'b0110: f = a ^ b;     4'b0111: f = a & ~b;
        4'b1000: f = ~a | b;    4'b1001: f = ~(a ^ b);
        4'b1010: f = b;         4'b1011: f = a & b;
        4'b1100: f = '1;        4'b1101: f = a | ~b;
        4'b1110: f = a | b;     default: f = a;
      endcase
      return {1'b1, f};
    end
    case (s)
      4'b0000: begin p = a;      q = '0;      end
      4'b0001: begin p = a | b;  q = '0;      end
      4'b0010: begin p = a | ~b; q = '0;      end
      4'b0011: begin p = '0;     q = '1;      end
      4'b0100: begin p = a;      q = a & ~b;  end
      4'b0101: begin p = a | b;  q = a & ~b;  end
      4'b0110: begin p = a;      q = ~b;      end
      4'b0111: begin p = a & ~b; q = '1;      end
      4'b1000: begin p = a;      q = a & b;   end
      4'b1001: begin p = a;      q = b;       end
      4'b1010: begin p = a | ~b; q = a & b;   end
      4'b1011: begin p = a & b;  q = '1;      end
      4'b1100: begin p = a;      q = a;       end
      4'b1101: begin p = a | b;  q = a;       end
      4'b1110: begin p = a | ~b; q = a;       end
      default: begin p = a;      q = '1;      end
    endcase
    sum = {1'b0, p} + {1'b0, q} + {{W{1'b0}}, ~cn};
    return {~sum[W], sum[W-1:0]};
  endfunction

  assign {alu_cout, alu_f} = alu181(alu_select, alu_mode, alu_cin, alu_a, alu_b);
  assign alu_equal = &alu_f;

  typedef struct {
    logic [1:0]   op;
    logic [3:0]   sel;
    logic         mode;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         carry, eq, gt, err;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         carry, eq, gt, err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: compare each response at the negedge before its handshake edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_result", {16'd0, rsp_result}, {16'd0, mon_e.res});
        check("rsp_carry", {31'd0, rsp_carry}, {31'd0, mon_e.carry});
        check("rsp_eq", {31'd0, rsp_eq}, {31'd0, mon_e.eq});
        check("rsp_gt", {31'd0, rsp_gt}, {31'd0, mon_e.gt});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] sel, input logic mode,
                              input logic cin, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] res, input logic carry, input logic eq,
                              input logic gt, input logic err, input int lat);
    vec_t v;
    v.op = op; v.sel = sel; v.mode = mode; v.cin = cin; v.a = a; v.b = b;
    v.res = res; v.carry = carry; v.eq = eq; v.gt = gt; v.err = err; v.lat = lat;
    return v;
  endfunction

  // Waits for cmd_ready, then presents the command for exactly one handshake edge.
  task automatic issue(input vec_t v, input bit push);
    exp_t e;
    int   n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (cmd_ready !== 1'b1) begin
      check("cmd_ready_timeout", 32'd0, 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = v.op; cmd_select = v.sel; cmd_mode = v.mode;
    cmd_cin = v.cin; cmd_a = v.a; cmd_b = v.b;
    if (push) begin
      e.res = v.res; e.carry = v.carry; e.eq = v.eq; e.gt = v.gt; e.err = v.err;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Latency = edges after the handshake edge up to the first edge sampling rsp_valid high.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (rsp_valid !== 1'b1) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    issue(v, 1'b1);
    wait_rsp(lat);
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_cmd_ready_busy"}, {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_rsp_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_cmd_ready_back"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_bus"}, {11'd0, rsp_result, rsp_carry, rsp_eq, rsp_gt, rsp_err, 1'b0}, 32'd0);
    check({tag, "_alu_bus"}, {10'd0, alu_select, alu_mode, alu_cin, alu_a}, 32'd0);
    check({tag, "_alu_b"}, {16'd0, alu_b}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[14];
    vec_t v;
    logic [W-1:0] held;

    vecs[0]  = mk(2'b00, 4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    vecs[1]  = mk(2'b00, 4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    vecs[2]  = mk(2'b00, 4'b1001, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    vecs[3]  = mk(2'b00, 4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    vecs[4]  = mk(2'b00, 4'b1100, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    vecs[5]  = mk(2'b10, 4'b0000, 1'b1, 1'b0, 16'h00A5, 16'h00A5, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    vecs[6]  = mk(2'b10, 4'b0000, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    vecs[7]  = mk(2'b10, 4'b1111, 1'b1, 1'b0, 16'h0003, 16'h0007, 16'hFFFB, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    vecs[8]  = mk(2'b01, 4'b0000, 1'b0, 1'b0, 16'hC001, 16'h0003, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    vecs[9]  = mk(2'b01, 4'b0000, 1'b0, 1'b0, 16'hC001, 16'h0000, 16'hC001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    vecs[10] = mk(2'b01, 4'b0000, 1'b0, 1'b0, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    vecs[11] = mk(2'b01, 4'b0000, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    vecs[12] = mk(2'b11, 4'b1001, 1'b0, 1'b1, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    vecs[13] = mk(2'b01, 4'b0000, 1'b0, 1'b0, 16'hFFFF, 16'hABCF, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 16);

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_select = 4'd0; cmd_mode = 1'b0;
    cmd_cin = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response must hold while extra requests are ignored.
    rsp_ready = 1'b0;
    v = vecs[0];
    issue(v, 1'b1);
    begin
      int lat;
      wait_rsp(lat);
      check("bp_latency", lat, 2);
    end
    held = rsp_result;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 16'h5555; cmd_b = 16'h1111;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid_c%0d", c), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp_ready_c%0d", c), {31'd0, cmd_ready}, 32'd0);
      check($sformatf("bp_result_c%0d", c), {16'd0, rsp_result}, 32'h0000_2233);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("bp_held_value", {16'd0, held}, 32'h0000_2233);

    // Reset four edges into a 10-step shift: nothing may come out.
    v = mk(2'b01, 4'b0000, 1'b0, 1'b0, 16'h1234, 16'h000A, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 11);
    issue(v, 1'b0);
    for (int c = 1; c < 4; c++) begin
      check($sformatf("rst_shl_valid_k%0d", c), {31'd0, rsp_valid}, 32'd0);
      check($sformatf("rst_shl_ready_k%0d", c), {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midshl_reset");
    @(posedge clk); #1;
    check("midshl_idle_valid", {31'd0, rsp_valid}, 32'd0);
    run_vec(vecs[0], "after_reset");

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
